// File: rtl/abcd_sweep_checker_if.sv
// -----------------------------------------------------------------------------
// abcd_sweep_checker_if
// Groups the stimulus/response signals of the ABCD sweep checker.
//   i_start        : one-cycle pulse that begins a sweep when the checker is idle/done
//   i_f_in         : F output of the function block under check
//   o_abcd_out     : drive vector to the function block, [3]=A [2]=B [1]=C [0]=D
//   o_busy         : sweep in progress
//   o_done         : sweep complete, results valid
//   o_pass         : valid while o_done, 1 when no mismatch was recorded
//   o_truth_table  : captured F per code, bit i = F sampled at ABCD = i
//   o_mismatch_cnt : number of mismatching codes (0..16)
//   o_first_fail   : lowest mismatching code, valid when o_fail_seen
//   o_fail_seen    : at least one mismatch recorded in the current sweep
// The slave modport is the checker side; the master modport is the side that
// starts sweeps, supplies F and observes the results.
// -----------------------------------------------------------------------------
interface abcd_sweep_checker_if;

    logic        i_start;
    logic        i_f_in;
    logic [3:0]  o_abcd_out;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic [15:0] o_truth_table;
    logic [4:0]  o_mismatch_cnt;
    logic [3:0]  o_first_fail;
    logic        o_fail_seen;

    modport slave (
        input  i_start,
        input  i_f_in,
        output o_abcd_out,
        output o_busy,
        output o_done,
        output o_pass,
        output o_truth_table,
        output o_mismatch_cnt,
        output o_first_fail,
        output o_fail_seen
    );

    modport master (
        output i_start,
        output i_f_in,
        input  o_abcd_out,
        input  o_busy,
        input  o_done,
        input  o_pass,
        input  o_truth_table,
        input  o_mismatch_cnt,
        input  o_first_fail,
        input  o_fail_seen
    );

endinterface

// File: rtl/abcd_sweep_checker.sv
// -----------------------------------------------------------------------------
// abcd_sweep_checker
// Exhaustive stimulus/response stage for the combinational function
// F = (AB' + A'B)(C + D'). On an accepted start it walks ABCD through codes
// 0..15, holds each code for DWELL cycles, samples F on the last cycle of
// each hold, builds the captured truth table and compares it against the
// golden table EXPECTED.
//
// Parameters:
//   DWELL    : cycles each code is held before F is sampled (1..255)
//   EXPECTED : golden truth table, bit i = expected F for ABCD = i
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : abcd_sweep_checker_if.slave (start, f_in, drive vector, results)
//
// All outputs come straight from registers; neither i_start nor i_f_in has a
// combinational path to any output.
// -----------------------------------------------------------------------------
module abcd_sweep_checker #(
    parameter int unsigned DWELL    = 4,
    parameter logic [15:0] EXPECTED = 16'h0DD0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    abcd_sweep_checker_if.slave   bus
);

    // Counter reload value: a count of DWELL-1 down to 0 spans DWELL cycles.
    localparam logic [7:0] DWELL_RELOAD = 8'(DWELL - 1);
    localparam logic [3:0] LAST_CODE    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    state_e      r_state;
    logic [3:0]  r_abcd;
    logic [7:0]  r_dwell_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [15:0] r_truth_table;
    logic [4:0]  r_mismatch_cnt;
    logic [3:0]  r_first_fail;
    logic        r_fail_seen;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_e      w_next_state;
    logic [3:0]  w_next_abcd;
    logic [7:0]  w_next_dwell_cnt;
    logic        w_next_busy;
    logic        w_next_done;
    logic        w_next_pass;
    logic [15:0] w_next_truth_table;
    logic [4:0]  w_next_mismatch_cnt;
    logic [3:0]  w_next_first_fail;
    logic        w_next_fail_seen;

    // Golden F for the code currently driven.
    function automatic logic expected_bit(input logic [15:0] table_v, input logic [3:0] code);
        return table_v[code];
    endfunction

    // Next-state and result update logic for the sweep FSM.
    always_comb begin
        w_next_state        = r_state;
        w_next_abcd         = r_abcd;
        w_next_dwell_cnt    = r_dwell_cnt;
        w_next_busy         = r_busy;
        w_next_done         = r_done;
        w_next_pass         = r_pass;
        w_next_truth_table  = r_truth_table;
        w_next_mismatch_cnt = r_mismatch_cnt;
        w_next_first_fail   = r_first_fail;
        w_next_fail_seen    = r_fail_seen;

        case (r_state)
            // IDLE and DONE accept a start identically; results of the
            // previous sweep are discarded on the accepting edge.
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    w_next_state        = ST_DRIVE;
                    w_next_abcd         = 4'd0;
                    w_next_dwell_cnt    = DWELL_RELOAD;
                    w_next_busy         = 1'b1;
                    w_next_done         = 1'b0;
                    w_next_pass         = 1'b0;
                    w_next_truth_table  = 16'h0000;
                    w_next_mismatch_cnt = 5'd0;
                    w_next_first_fail   = 4'd0;
                    w_next_fail_seen    = 1'b0;
                end else begin
                    w_next_state = r_state;
                end
            end

            // i_start is not looked at here, so a pulse mid-sweep is ignored.
            ST_DRIVE: begin
                if (r_dwell_cnt != 8'd0) begin
                    w_next_dwell_cnt = r_dwell_cnt - 8'd1;
                end else begin
                    // Dwell-terminal cycle: this is the only cycle F is used.
                    w_next_truth_table[r_abcd] = bus.i_f_in;

                    if (bus.i_f_in != expected_bit(EXPECTED, r_abcd)) begin
                        w_next_mismatch_cnt = r_mismatch_cnt + 5'd1;
                        if (!r_fail_seen) begin
                            w_next_first_fail = r_abcd;
                            w_next_fail_seen  = 1'b1;
                        end else begin
                            w_next_first_fail = r_first_fail;
                        end
                    end else begin
                        w_next_mismatch_cnt = r_mismatch_cnt;
                    end

                    if (r_abcd != LAST_CODE) begin
                        w_next_abcd      = r_abcd + 4'd1;
                        w_next_dwell_cnt = DWELL_RELOAD;
                    end else begin
                        // Last code sampled: pass must include this final sample,
                        // so it is derived from the updated count, not r_mismatch_cnt.
                        w_next_state = ST_DONE;
                        w_next_busy  = 1'b0;
                        w_next_done  = 1'b1;
                        w_next_pass  = (w_next_mismatch_cnt == 5'd0);
                    end
                end
            end

            default: begin
                w_next_state     = ST_IDLE;
                w_next_abcd      = 4'd0;
                w_next_dwell_cnt = 8'd0;
                w_next_busy      = 1'b0;
                w_next_done      = 1'b0;
                w_next_pass      = 1'b0;
            end
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_abcd         <= 4'd0;
            r_dwell_cnt    <= 8'd0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_truth_table  <= 16'h0000;
            r_mismatch_cnt <= 5'd0;
            r_first_fail   <= 4'd0;
            r_fail_seen    <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_abcd         <= w_next_abcd;
            r_dwell_cnt    <= w_next_dwell_cnt;
            r_busy         <= w_next_busy;
            r_done         <= w_next_done;
            r_pass         <= w_next_pass;
            r_truth_table  <= w_next_truth_table;
            r_mismatch_cnt <= w_next_mismatch_cnt;
            r_first_fail   <= w_next_first_fail;
            r_fail_seen    <= w_next_fail_seen;
        end
    end

    // Outputs are direct register copies.
    assign bus.o_abcd_out     = r_abcd;
    assign bus.o_busy         = r_busy;
    assign bus.o_done         = r_done;
    assign bus.o_pass         = r_pass;
    assign bus.o_truth_table  = r_truth_table;
    assign bus.o_mismatch_cnt = r_mismatch_cnt;
    assign bus.o_first_fail   = r_first_fail;
    assign bus.o_fail_seen    = r_fail_seen;

endmodule

// File: tb/tb_abcd_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_abcd_sweep_checker
// Two checkers (DWELL=4 and DWELL=1) driven by a behavioural device: F for
// each code comes from a 16-bit "device table". Expected results come from
// plain arithmetic on that table versus the golden table.
// -----------------------------------------------------------------------------
module tb_abcd_sweep_checker;

    localparam logic [15:0] GOLDEN = 16'h0DD0;
    localparam int          DW_A   = 4;
    localparam int          DW_B   = 1;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst_n  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    abcd_sweep_checker_if bus_a ();
    abcd_sweep_checker_if bus_b ();

    abcd_sweep_checker #(.DWELL(DW_A), .EXPECTED(GOLDEN)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    abcd_sweep_checker #(.DWELL(DW_B), .EXPECTED(GOLDEN)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    always #5 clk = clk_en ? ~clk : 1'b0;

    // Stimulus control shared by both checkers; sel picks the one under test.
    logic        sel     = 1'b0;
    logic        start_s = 1'b0;
    logic [15:0] dev     = GOLDEN;
    logic        glitch  = 1'b0;

    assign bus_a.i_start = start_s & ~sel;
    assign bus_b.i_start = start_s &  sel;
    assign bus_b.i_f_in  = dev[bus_b.o_abcd_out];

    // Observed outputs of the selected checker.
    wire [3:0]  obs_abcd = sel ? bus_b.o_abcd_out     : bus_a.o_abcd_out;
    wire        obs_busy = sel ? bus_b.o_busy         : bus_a.o_busy;
    wire        obs_done = sel ? bus_b.o_done         : bus_a.o_done;
    wire        obs_pass = sel ? bus_b.o_pass         : bus_a.o_pass;
    wire [15:0] obs_tt   = sel ? bus_b.o_truth_table  : bus_a.o_truth_table;
    wire [4:0]  obs_mm   = sel ? bus_b.o_mismatch_cnt : bus_a.o_mismatch_cnt;
    wire [3:0]  obs_ff   = sel ? bus_b.o_first_fail   : bus_a.o_first_fail;
    wire        obs_fs   = sel ? bus_b.o_fail_seen    : bus_a.o_fail_seen;

    // Device for checker A: the true F is presented on the DW_A-th cycle of
    // each code's hold; earlier cycles carry random garbage when glitch is on.
    int         age_a       = 0;
    logic [3:0] last_abcd_a = 4'd0;
    logic       last_busy_a = 1'b0;
    initial bus_a.i_f_in = 1'b0;
    always @(negedge clk) begin
        if (!bus_a.o_busy)
            age_a = 0;
        else if (!last_busy_a || bus_a.o_abcd_out != last_abcd_a)
            age_a = 1;
        else
            age_a = age_a + 1;
        last_busy_a = bus_a.o_busy;
        last_abcd_a = bus_a.o_abcd_out;
        if (glitch && bus_a.o_busy && age_a != DW_A)
            bus_a.i_f_in = 1'($urandom_range(0, 1));
        else
            bus_a.i_f_in = dev[bus_a.o_abcd_out];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int popcount16(input logic [15:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int lowest_set(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Runs one sweep on the selected checker. A second start pulse is given
    // after inject_at edges (negative = none). Checks clearing on the
    // accepting edge, the code schedule, the latency and the final results.
    task automatic run_sweep(input int inject_at);
        int dwell;
        int edges;
        int bad_steps;
        logic [15:0] diff;
        dwell = sel ? DW_B : DW_A;
        bad_steps = 0;
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        edges = 1;
        check("accept_busy", 32'(obs_busy), 32'd1);
        check("accept_done", 32'(obs_done), 32'd0);
        check("accept_pass", 32'(obs_pass), 32'd0);
        check("accept_tt",   32'(obs_tt),   32'd0);
        check("accept_mm",   32'(obs_mm),   32'd0);
        check("accept_fs",   32'(obs_fs),   32'd0);
        check("accept_ff",   32'(obs_ff),   32'd0);
        check("accept_abcd", 32'(obs_abcd), 32'd0);
        while (!obs_done && edges < 2000) begin
            @(negedge clk);
            if (edges == inject_at) start_s = 1'b1;
            @(posedge clk); #1;
            start_s = 1'b0;
            edges++;
            // Code k is on the outputs for edges 1+k*dwell .. k*dwell+dwell.
            if (obs_abcd !== 4'(((edges - 1) / dwell > 15) ? 15 : (edges - 1) / dwell))
                bad_steps++;
        end
        check("code_schedule", 32'(bad_steps), 32'd0);
        check("latency", 32'(edges), 32'(16 * dwell + 1));
        diff = dev ^ GOLDEN;
        check("done_busy", 32'(obs_busy), 32'd0);
        check("done_done", 32'(obs_done), 32'd1);
        check("done_abcd", 32'(obs_abcd), 32'd15);
        check("truth_table", 32'(obs_tt), 32'(dev));
        check("mismatch_cnt", 32'(obs_mm), 32'(popcount16(diff)));
        check("fail_seen", 32'(obs_fs), 32'(diff != 16'h0000));
        check("first_fail", 32'(obs_ff), 32'(lowest_set(diff)));
        check("pass", 32'(obs_pass), 32'(diff == 16'h0000));
        // Results must hold while idle in DONE.
        repeat (3) @(posedge clk);
        #1;
        check("hold_tt", 32'(obs_tt), 32'(dev));
        check("hold_done", 32'(obs_done), 32'd1);
    endtask

    initial begin
        int waited;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_abcd_a", 32'(bus_a.o_abcd_out), 32'd0);
        check("rst_busy_a", 32'(bus_a.o_busy), 32'd0);
        check("rst_done_a", 32'(bus_a.o_done), 32'd0);
        check("rst_pass_a", 32'(bus_a.o_pass), 32'd0);
        check("rst_tt_a",   32'(bus_a.o_truth_table), 32'd0);
        check("rst_mm_a",   32'(bus_a.o_mismatch_cnt), 32'd0);
        check("rst_busy_b", 32'(bus_b.o_busy), 32'd0);

        // DWELL=4: correct device, stuck-at-0, stuck-at-1 (restart from DONE).
        sel = 1'b0;
        dev = GOLDEN;       run_sweep(-1);
        dev = 16'h0000;     run_sweep(-1);
        check("stuck0_mm", 32'(bus_a.o_mismatch_cnt), 32'd6);
        check("stuck0_ff", 32'(bus_a.o_first_fail), 32'd4);
        dev = 16'hFFFF;     run_sweep(-1);
        check("stuck1_mm", 32'(bus_a.o_mismatch_cnt), 32'd10);
        check("stuck1_ff", 32'(bus_a.o_first_fail), 32'd0);
        dev = 16'hFFFF;     run_sweep(-1);

        // Ignored start mid-sweep, then random devices with glitches between samples.
        dev = GOLDEN;       run_sweep(10);
        glitch = 1'b1;
        for (int r = 0; r < 4; r++) begin
            dev = 16'($urandom);
            run_sweep(5 + r * 7);
        end
        glitch = 1'b0;

        // DWELL=1: correct device then random devices.
        sel = 1'b1;
        dev = GOLDEN;       run_sweep(-1);
        for (int r = 0; r < 3; r++) begin
            dev = 16'($urandom);
            run_sweep(3);
        end

        // Asynchronous reset mid-sweep with the clock stopped.
        sel = 1'b0;
        dev = GOLDEN;
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        waited = 0;
        while (bus_a.o_abcd_out != 4'd7 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check("reach_code7", 32'(bus_a.o_abcd_out), 32'd7);
        clk_en = 1'b0;
        #12;
        rst_n = 1'b0;
        #1;
        check("arst_abcd", 32'(bus_a.o_abcd_out), 32'd0);
        check("arst_busy", 32'(bus_a.o_busy), 32'd0);
        check("arst_done", 32'(bus_a.o_done), 32'd0);
        check("arst_pass", 32'(bus_a.o_pass), 32'd0);
        check("arst_tt",   32'(bus_a.o_truth_table), 32'd0);
        check("arst_mm",   32'(bus_a.o_mismatch_cnt), 32'd0);
        check("arst_ff",   32'(bus_a.o_first_fail), 32'd0);
        check("arst_fs",   32'(bus_a.o_fail_seen), 32'd0);
        #5;
        rst_n = 1'b1;
        clk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(bus_a.o_busy), 32'd0);
        check("post_rst_done", 32'(bus_a.o_done), 32'd0);
        check("post_rst_abcd", 32'(bus_a.o_abcd_out), 32'd0);

        // A fresh start after reset runs a full sweep.
        dev = 16'h0DC0;     run_sweep(-1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
